audio_system: RTL and testbench

//  Top level of the JTAG-loaded audio player. A host loads 16-bit PCM samples into on-chip RAM

---
 rtl/audio_system.sv | 176 +++++++++++++++++
 tb/tb_audio_system.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/audio_system.sv
// rtl/audio_system.sv - JTAG-loaded sample player: tck-side loader, dual-clock RAM, playback and PDM output
module vjtag_tap #(
    parameter int IR_W = 4
) (
    input  logic            tdo,
    output logic            tck,
    output logic            tdi,
    output logic [IR_W-1:0] ir_in,
    output logic            cdr,
    output logic            sdr,
    output logic            udr
);
    // Stand-in for the vendor virtual-JTAG primitive: strobes idle, tdo looped back to tdi.
    assign tck   = 1'b0;
    assign tdi   = tdo;
    assign ir_in = '0;
    assign cdr   = 1'b0;
    assign sdr   = 1'b0;
    assign udr   = 1'b0;
endmodule

module audio_system #(
    parameter int ADDR_W     = 10,
    parameter int SAMPLE_DIV = 1134,
    parameter int IR_W       = 4
) (
    input  logic       clk_50_,
    input  logic       rst_n_,
    output logic [7:0] nano_led_,
    output logic       audio_out_
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CTRL_W = ADDR_W + 3;
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [IR_W-1:0] IR_LED    = IR_W'(1);
    localparam logic [IR_W-1:0] IR_WADDR  = IR_W'(2);
    localparam logic [IR_W-1:0] IR_WDATA  = IR_W'(3);
    localparam logic [IR_W-1:0] IR_CTRL   = IR_W'(4);
    localparam logic [IR_W-1:0] IR_STATUS = IR_W'(5);

    logic            tck, tdi, tdo, cdr, sdr, udr;
    logic [IR_W-1:0] ir_in;

    vjtag_tap #(.IR_W(IR_W)) u_tap (
        .tdo(tdo), .tck(tck), .tdi(tdi), .ir_in(ir_in), .cdr(cdr), .sdr(sdr), .udr(udr)
    );

    logic [1:0]        rst_tck_q, rst_clk_q;
    logic              rst_tck_n, rst_clk_n;
    logic [15:0]       dr, dr_shift;
    logic [7:0]        led_hold;
    logic [CTRL_W-1:0] ctrl_hold;
    logic              led_tgl, ctrl_tgl;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       mem [DEPTH];

    logic [2:0]        led_sync, ctrl_sync;
    logic              led_pulse, ctrl_pulse;
    logic [7:0]        led_reg;
    logic              play, loop, led_src;
    logic [ADDR_W-1:0] end_addr, ram_rd_addr;
    logic [DIV_W-1:0]  div;
    logic [15:0]       rd_data, sample, u, acc;
    logic [16:0]       pdm_sum;

    always_ff @(posedge tck or negedge rst_n_) begin
        if (!rst_n_) rst_tck_q <= '0;
        else         rst_tck_q <= {rst_tck_q[0], 1'b1};
    end
    assign rst_tck_n = rst_tck_q[1];

    always_ff @(posedge clk_50_ or negedge rst_n_) begin
        if (!rst_n_) rst_clk_q <= '0;
        else         rst_clk_q <= {rst_clk_q[0], 1'b1};
    end
    assign rst_clk_n = rst_clk_q[1];

    // LSB-first shift: tdi enters at the top bit of the selected register's length.
    always_comb begin
        dr_shift = {1'b0, dr[15:1]};
        case (ir_in)
            IR_LED:    dr_shift[7]        = tdi;
            IR_WADDR:  dr_shift[ADDR_W-1] = tdi;
            IR_WDATA:  dr_shift[15]       = tdi;
            IR_CTRL:   dr_shift[CTRL_W-1] = tdi;
            IR_STATUS: dr_shift[ADDR_W]   = tdi;
            default:   dr_shift[0]        = tdi;
        endcase
    end
    assign tdo = dr[0];

    // STATUS samples clk-domain state directly; the host reads it while playback is idle.
    always_ff @(posedge tck or negedge rst_tck_n) begin
        if (!rst_tck_n) begin
            dr        <= '0;
            led_hold  <= '0;
            ctrl_hold <= '0;
            led_tgl   <= 1'b0;
            ctrl_tgl  <= 1'b0;
            wr_addr   <= '0;
        end else if (cdr) begin
            dr <= (ir_in == IR_STATUS) ? 16'({play, ram_rd_addr}) : '0;
        end else if (sdr) begin
            dr <= dr_shift;
        end else if (udr) begin
            case (ir_in)
                IR_LED:   begin led_hold <= dr[7:0];         led_tgl  <= ~led_tgl;  end
                IR_WADDR: wr_addr <= dr[ADDR_W-1:0];
                IR_WDATA: wr_addr <= wr_addr + 1'b1;
                IR_CTRL:  begin ctrl_hold <= dr[CTRL_W-1:0]; ctrl_tgl <= ~ctrl_tgl; end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge tck) begin
        if (rst_tck_n && udr && !cdr && !sdr && ir_in == IR_WDATA) mem[wr_addr] <= dr;
    end

    always_ff @(posedge clk_50_) rd_data <= mem[ram_rd_addr];

    assign led_pulse  = led_sync[1] ^ led_sync[2];
    assign ctrl_pulse = ctrl_sync[1] ^ ctrl_sync[2];
    assign u          = sample ^ 16'h8000;
    assign pdm_sum    = {1'b0, acc} + {1'b0, u};

    always_ff @(posedge clk_50_ or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            led_sync    <= '0;
            ctrl_sync   <= '0;
            led_reg     <= '0;
            play        <= 1'b0;
            loop        <= 1'b0;
            led_src     <= 1'b0;
            end_addr    <= '0;
            ram_rd_addr <= '0;
            div         <= '0;
            sample      <= '0;
            acc         <= '0;
            audio_out_  <= 1'b0;
            nano_led_   <= '0;
        end else begin
            led_sync  <= {led_sync[1:0], led_tgl};
            ctrl_sync <= {ctrl_sync[1:0], ctrl_tgl};
            if (led_pulse) led_reg <= led_hold;
            if (ctrl_pulse) begin
                end_addr <= ctrl_hold[CTRL_W-1:3];
                loop     <= ctrl_hold[2];
                led_src  <= ctrl_hold[1];
                play     <= ctrl_hold[0];
                if (ctrl_hold[0] && !play) begin
                    ram_rd_addr <= '0;
                    div         <= '0;
                end
                // A host stop returns the output to the mid-scale idle level.
                if (!ctrl_hold[0]) sample <= '0;
            end else if (play) begin
                if (div == DIV_LAST) begin
                    div    <= '0;
                    sample <= rd_data;
                    if (ram_rd_addr == end_addr) begin
                        if (loop) ram_rd_addr <= '0;
                        else      play        <= 1'b0;
                    end else begin
                        ram_rd_addr <= ram_rd_addr + 1'b1;
                    end
                end else begin
                    div <= div + 1'b1;
                end
            end
            {audio_out_, acc} <= pdm_sum;
            nano_led_ <= led_src ? u[15:8] : led_reg;
        end
    end
endmodule

// File: tb/tb_audio_system.sv
// tb/tb_audio_system.sv - scoreboard bench for audio_system driving the virtual TAP pins
module tb_audio_system;
    logic       clk_50_ = 1'b0;
    logic       rst_n_  = 1'b0;
    logic [7:0] nano_led_;
    logic       audio_out_;

    logic       tck_b = 1'b0;
    logic [3:0] ir_v  = 4'h0;
    logic       tdi_v = 1'b0, cdr_v = 1'b0, sdr_v = 1'b0, udr_v = 1'b0;

    int n_cmp = 0, n_bad = 0, cyc = 0, last_cyc = 0, last_delta = 0, ones = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  led_prev = 8'h00;
    logic [15:0] cap;

    audio_system #(.ADDR_W(10), .SAMPLE_DIV(8), .IR_W(4)) dut (
        .clk_50_(clk_50_), .rst_n_(rst_n_), .nano_led_(nano_led_), .audio_out_(audio_out_)
    );

    always #10 clk_50_ = ~clk_50_;
    always @(posedge clk_50_) cyc++;

    initial begin
        force dut.tck = 1'b0;
        forever begin
            #13 tck_b = 1'b1; force dut.tck = 1'b1;
            #13 tck_b = 1'b0; force dut.tck = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_tap();
        force dut.ir_in = ir_v;
        force dut.tdi   = tdi_v;
        force dut.cdr   = cdr_v;
        force dut.sdr   = sdr_v;
        force dut.udr   = udr_v;
    endtask

    task automatic scan(input logic [3:0] ir, input logic [15:0] data, input int len,
                        output logic [15:0] captured);
        captured = '0;
        @(negedge tck_b);
        ir_v = ir; cdr_v = 1'b1; drive_tap();
        @(negedge tck_b);
        cdr_v = 1'b0; sdr_v = 1'b1;
        for (int i = 0; i < len; i++) begin
            captured[i] = dut.tdo;
            tdi_v = data[i];
            drive_tap();
            @(negedge tck_b);
        end
        sdr_v = 1'b0; udr_v = 1'b1; drive_tap();
        @(negedge tck_b);
        udr_v = 1'b0; drive_tap();
    endtask

    task automatic expect_led(input string tag, input int budget);
        logic [7:0] exp_v;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk_50_);
            if (nano_led_ !== led_prev) seen = 1'b1;
        end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check(tag, 32'(nano_led_), 32'(exp_v));
        led_prev   = nano_led_;
        last_delta = cyc - last_cyc;
        last_cyc   = cyc;
    endtask

    task automatic count_ones(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_50_);
            cnt += int'(audio_out_);
        end
    endtask

    initial begin
        drive_tap();
        #100;
        check("reset_led", 32'(nano_led_), 32'h00);
        check("reset_audio", 32'(audio_out_), 32'h0);
        @(negedge clk_50_);
        rst_n_ = 1'b1;
        repeat (6) @(negedge clk_50_);
        count_ones(32, ones);
        check("idle_duty", 32'(ones), 32'd16);

        exp_q.push_back(8'hA5);
        scan(4'h1, 16'h00A5, 8, cap);
        expect_led("led_a5", 5);

        scan(4'h2, 16'd1023, 10, cap);
        scan(4'h3, 16'h5555, 16, cap);
        check("waddr_wrap", 32'(dut.wr_addr), 32'd0);
        scan(4'h2, 16'd0, 10, cap);
        scan(4'h3, 16'h1234, 16, cap);
        scan(4'h3, 16'h7FFF, 16, cap);
        scan(4'h3, 16'h8000, 16, cap);
        check("waddr_after_3", 32'(dut.wr_addr), 32'd3);

        // end=2 loop=0 led_src=1 play=1; led_src first exposes the idle sample
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h92);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        scan(4'h4, 16'h0013, 13, cap);
        expect_led("oneshot_idle", 10);
        expect_led("oneshot_s0", 20);
        expect_led("oneshot_s1", 20);
        check("oneshot_gap1", 32'(last_delta), 32'd8);
        expect_led("oneshot_s2", 20);
        check("oneshot_gap2", 32'(last_delta), 32'd8);
        repeat (16) @(negedge clk_50_);
        check("stopped_led", 32'(nano_led_), 32'h00);
        count_ones(32, ones);
        check("zero_sample_density", 32'(ones), 32'd0);
        scan(4'h5, 16'h0000, 11, cap);
        check("status_after_stop", 32'(cap[10:0]), 32'h002);

        exp_q.push_back(8'h92);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h92);
        exp_q.push_back(8'hFF);
        scan(4'h4, 16'h0017, 13, cap);
        expect_led("loop_s0", 20);
        expect_led("loop_s1", 20);
        check("loop_gap1", 32'(last_delta), 32'd8);
        count_ones(6, ones);
        check("ff_density", 32'(ones >= 5), 32'd1);
        expect_led("loop_s2", 20);
        check("loop_gap2", 32'(last_delta), 32'd8);
        count_ones(6, ones);
        check("00_density", 32'(ones), 32'd0);
        expect_led("loop_wrap_s0", 20);
        check("loop_gap3", 32'(last_delta), 32'd8);
        expect_led("loop_wrap_s1", 20);
        check("loop_gap4", 32'(last_delta), 32'd8);

        @(negedge clk_50_);
        #3 rst_n_ = 1'b0;
        #1;
        check("midreset_led", 32'(nano_led_), 32'h00);
        check("midreset_audio", 32'(audio_out_), 32'h0);
        check("midreset_play", 32'(dut.play), 32'h0);
        check("midreset_rd_addr", 32'(dut.ram_rd_addr), 32'h0);
        check("midreset_led_reg", 32'(dut.led_reg), 32'h0);
        check("midreset_wr_addr", 32'(dut.wr_addr), 32'h0);
        check("midreset_acc", 32'(dut.acc), 32'h0);
        #50;
        @(negedge clk_50_);
        rst_n_ = 1'b1;
        repeat (8) @(negedge clk_50_);
        count_ones(16, ones);
        check("post_reset_duty", 32'(ones), 32'd8);
        check("post_reset_led", 32'(nano_led_), 32'h00);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
